// File: rtl/tile_pe_db.sv
// Double-buffered weight MAC tile: streams x through, adds weight*x to a partial sum
// over a two-stage pipeline, with tile-addressed shadow-bank config and hold-aware swaps.
module tile_pe_db #(
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int NW    = 4,
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  localparam int WI_W = $clog2(NW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROW_W-1:0]       core_row,
  input  logic [COL_W-1:0]       core_col,
  input  logic [ROW_W+COL_W-1:0] cfg_addr,
  input  logic [WI_W-1:0]        cfg_widx,
  input  logic [DW-1:0]          cfg_data,
  input  logic                   cfg_valid,
  input  logic                   cfg_swap,
  input  logic                   mode_signed,
  input  logic                   sat_en,
  input  logic [WI_W-1:0]        w_sel,
  input  logic                   hold,
  input  logic                   clr,
  input  logic [DW-1:0]          x_in,
  input  logic                   x_valid_in,
  input  logic [ACC_W-1:0]       acc_in,
  input  logic                   acc_valid_in,
  output logic [DW-1:0]          x_out,
  output logic                   x_valid_out,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   acc_valid_out,
  output logic                   ovf_flag,
  output logic [15:0]            mac_cnt
);

  typedef enum logic {S_IDLE, S_PEND} swap_st_e;

  swap_st_e          swap_st_q, swap_st_d;
  logic              bank_sel_q, bank_sel_d;
  logic [DW-1:0]     bank_q [2][NW];
  logic [DW-1:0]     bank_d [2][NW];

  logic [ACC_W-1:0]  s1_acc_q, s1_acc_d;
  logic [2*DW-1:0]   s1_prod_q, s1_prod_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_xv_q, s1_xv_d;
  logic              s1_sgn_q, s1_sgn_d;

  logic [DW-1:0]     x_out_q, x_out_d;
  logic              x_valid_out_q, x_valid_out_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              acc_valid_out_q, acc_valid_out_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic [15:0]       mac_cnt_q, mac_cnt_d;

  logic              cfg_hit;
  logic [DW-1:0]     w_act;
  logic [2*DW-1:0]   w_ext, x_ext, prod_c;
  logic [ACC_W-1:0]  prod_ext, res;
  logic [ACC_W:0]    sum;
  logic              ovf;

  assign cfg_hit = cfg_valid && ((cfg_addr == {core_row, core_col}) || (&cfg_addr));
  assign w_act   = bank_q[bank_sel_q][w_sel];

  always_comb begin
    swap_st_d  = swap_st_q;
    bank_sel_d = bank_sel_q;
    bank_d     = bank_q;
    // Shadow is chosen from the pre-swap bank_sel, so a same-cycle write lands in the bank being activated.
    if (cfg_hit) bank_d[~bank_sel_q][cfg_widx] = cfg_data;
    case (swap_st_q)
      S_IDLE: begin
        if (cfg_swap) begin
          if (hold) swap_st_d = S_PEND;
          else      bank_sel_d = ~bank_sel_q;
        end
      end
      S_PEND: begin
        if (!hold) begin
          bank_sel_d = ~bank_sel_q;
          swap_st_d  = S_IDLE;
        end
      end
      default: swap_st_d = S_IDLE;
    endcase
  end

  // Low 2*DW bits of the product of extended operands equal the signed or unsigned product.
  always_comb begin
    w_ext  = mode_signed ? {{DW{w_act[DW-1]}}, w_act} : {{DW{1'b0}}, w_act};
    x_ext  = mode_signed ? {{DW{x_in[DW-1]}}, x_in}   : {{DW{1'b0}}, x_in};
    prod_c = w_ext * x_ext;
  end

  always_comb begin
    prod_ext = s1_sgn_q ? {{(ACC_W-2*DW){s1_prod_q[2*DW-1]}}, s1_prod_q}
                        : {{(ACC_W-2*DW){1'b0}}, s1_prod_q};
    sum = {s1_sgn_q & s1_acc_q[ACC_W-1], s1_acc_q} + {s1_sgn_q & prod_ext[ACC_W-1], prod_ext};
    if (s1_sgn_q)
      ovf = (s1_acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != s1_acc_q[ACC_W-1]);
    else
      ovf = sum[ACC_W];
    res = sum[ACC_W-1:0];
    if (ovf && sat_en) begin
      if (!s1_sgn_q)                res = {ACC_W{1'b1}};
      else if (s1_acc_q[ACC_W-1])   res = {1'b1, {(ACC_W-1){1'b0}}};
      else                          res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    s1_acc_d        = s1_acc_q;
    s1_prod_d       = s1_prod_q;
    s1_vld_d        = s1_vld_q;
    s1_xv_d         = s1_xv_q;
    s1_sgn_d        = s1_sgn_q;
    x_out_d         = x_out_q;
    x_valid_out_d   = x_valid_out_q;
    acc_out_d       = acc_out_q;
    acc_valid_out_d = acc_valid_out_q;
    ovf_flag_d      = ovf_flag_q;
    mac_cnt_d       = mac_cnt_q;
    if (!hold) begin
      x_valid_out_d = x_valid_in;
      if (x_valid_in) x_out_d = x_in;
      s1_acc_d  = acc_in;
      s1_vld_d  = acc_valid_in;
      s1_xv_d   = x_valid_in;
      s1_sgn_d  = mode_signed;
      s1_prod_d = x_valid_in ? prod_c : '0;
      acc_valid_out_d = s1_vld_q;
      if (s1_vld_q) begin
        acc_out_d = res;
        if (ovf) ovf_flag_d = 1'b1;
        if (s1_xv_q && (mac_cnt_q != 16'hFFFF)) mac_cnt_d = mac_cnt_q + 16'd1;
      end
    end
    if (clr) begin
      ovf_flag_d = 1'b0;
      mac_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_st_q       <= S_IDLE;
      bank_sel_q      <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NW; i++)
          bank_q[b][i] <= '0;
      s1_acc_q        <= '0;
      s1_prod_q       <= '0;
      s1_vld_q        <= 1'b0;
      s1_xv_q         <= 1'b0;
      s1_sgn_q        <= 1'b0;
      x_out_q         <= '0;
      x_valid_out_q   <= 1'b0;
      acc_out_q       <= '0;
      acc_valid_out_q <= 1'b0;
      ovf_flag_q      <= 1'b0;
      mac_cnt_q       <= '0;
    end else begin
      swap_st_q       <= swap_st_d;
      bank_sel_q      <= bank_sel_d;
      bank_q          <= bank_d;
      s1_acc_q        <= s1_acc_d;
      s1_prod_q       <= s1_prod_d;
      s1_vld_q        <= s1_vld_d;
      s1_xv_q         <= s1_xv_d;
      s1_sgn_q        <= s1_sgn_d;
      x_out_q         <= x_out_d;
      x_valid_out_q   <= x_valid_out_d;
      acc_out_q       <= acc_out_d;
      acc_valid_out_q <= acc_valid_out_d;
      ovf_flag_q      <= ovf_flag_d;
      mac_cnt_q       <= mac_cnt_d;
    end
  end

  assign x_out         = x_out_q;
  assign x_valid_out   = x_valid_out_q;
  assign acc_out       = acc_out_q;
  assign acc_valid_out = acc_valid_out_q;
  assign ovf_flag      = ovf_flag_q;
  assign mac_cnt       = mac_cnt_q;

endmodule

// File: tb/tb_tile_pe_db.sv
// Directed bench for tile_pe_db: tile (1,2), inputs driven and outputs sampled on the falling edge.
module tb_tile_pe_db;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  core_row, core_col;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_widx;
  logic [7:0]  cfg_data;
  logic        cfg_valid, cfg_swap, mode_signed, sat_en;
  logic [1:0]  w_sel;
  logic        hold, clr;
  logic [7:0]  x_in;
  logic        x_valid_in;
  logic [23:0] acc_in;
  logic        acc_valid_in;
  logic [7:0]  x_out;
  logic        x_valid_out;
  logic [23:0] acc_out;
  logic        acc_valid_out;
  logic        ovf_flag;
  logic [15:0] mac_cnt;

  int checks = 0;
  int errors = 0;

  tile_pe_db dut (
    .clk(clk), .rst_n(rst_n), .core_row(core_row), .core_col(core_col),
    .cfg_addr(cfg_addr), .cfg_widx(cfg_widx), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_swap(cfg_swap), .mode_signed(mode_signed), .sat_en(sat_en), .w_sel(w_sel),
    .hold(hold), .clr(clr), .x_in(x_in), .x_valid_in(x_valid_in), .acc_in(acc_in),
    .acc_valid_in(acc_valid_in), .x_out(x_out), .x_valid_out(x_valid_out),
    .acc_out(acc_out), .acc_valid_out(acc_valid_out), .ovf_flag(ovf_flag), .mac_cnt(mac_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [1:0] idx, input logic [7:0] data);
    cfg_addr = addr; cfg_widx = idx; cfg_data = data; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_swap();
    cfg_swap = 1'b1;
    step();
    cfg_swap = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic xv, input logic [23:0] acc, input logic av);
    x_in = x; x_valid_in = xv; acc_in = acc; acc_valid_in = av;
  endtask

  task automatic test_reset();
    checks++;
    if ({x_out, x_valid_out, acc_out, acc_valid_out, ovf_flag, mac_cnt} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0h xv=%0b acc=%0h av=%0b ovf=%0b cnt=%0d, want all 0",
               x_out, x_valid_out, acc_out, acc_valid_out, ovf_flag, mac_cnt);
    end
  endtask

  task automatic test_basic();
    cfg_write(8'h12, 2'd0, 8'd3);
    do_swap();
    w_sel = 2'd0; mode_signed = 1'b0;
    send(8'd5, 1'b1, 24'd10, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    checks++;
    if (x_out !== 8'd5 || x_valid_out !== 1'b1) begin
      errors++; $display("FAIL basic_x_out: got %0d/%0b, want 5/1", x_out, x_valid_out);
    end
    checks++;
    if (acc_valid_out !== 1'b0) begin
      errors++; $display("FAIL basic_latency: acc_valid_out got %0b after 1 cycle, want 0", acc_valid_out);
    end
    step();
    checks++;
    if (acc_out !== 24'd25 || acc_valid_out !== 1'b1) begin
      errors++; $display("FAIL basic_acc: got %0d/%0b, want 25/1", acc_out, acc_valid_out);
    end
    checks++;
    if (mac_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_mac_cnt: got %0d, want 1", mac_cnt);
    end
  endtask

  task automatic test_signed();
    cfg_write(8'h12, 2'd1, 8'hFE);
    do_swap();
    w_sel = 2'd1; mode_signed = 1'b1;
    send(8'd100, 1'b1, 24'd0, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    step();
    checks++;
    if (acc_out !== 24'hFFFF38 || acc_valid_out !== 1'b1) begin
      errors++; $display("FAIL signed_mul: got %0h/%0b, want ffff38/1", acc_out, acc_valid_out);
    end
    checks++;
    if (ovf_flag !== 1'b0) begin
      errors++; $display("FAIL signed_no_ovf: ovf_flag got %0b, want 0", ovf_flag);
    end
  endtask

  task automatic test_saturate();
    cfg_write(8'h12, 2'd2, 8'd1);
    do_swap();
    w_sel = 2'd2; mode_signed = 1'b1; sat_en = 1'b1;
    send(8'd1, 1'b1, 24'h7FFFFF, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    step();
    checks++;
    if (acc_out !== 24'h7FFFFF || ovf_flag !== 1'b1) begin
      errors++; $display("FAIL sat_clamp: got %0h ovf=%0b, want 7fffff ovf=1", acc_out, ovf_flag);
    end
    sat_en = 1'b0;
    send(8'd1, 1'b1, 24'h7FFFFF, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    step();
    checks++;
    if (acc_out !== 24'h800000 || ovf_flag !== 1'b1) begin
      errors++; $display("FAIL sat_wrap: got %0h ovf=%0b, want 800000 ovf=1", acc_out, ovf_flag);
    end
    checks++;
    if (mac_cnt !== 16'd4) begin
      errors++; $display("FAIL sat_mac_cnt: got %0d, want 4", mac_cnt);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (ovf_flag !== 1'b0 || mac_cnt !== 16'd0) begin
      errors++; $display("FAIL clr: got ovf=%0b cnt=%0d, want 0/0", ovf_flag, mac_cnt);
    end
    mode_signed = 1'b0;
  endtask

  task automatic test_addr_decode();
    cfg_write(8'h34, 2'd3, 8'd9);
    do_swap();
    w_sel = 2'd3;
    send(8'd1, 1'b1, 24'd5, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    step();
    checks++;
    if (acc_out !== 24'd5) begin
      errors++; $display("FAIL addr_other_tile: got %0d, want 5", acc_out);
    end
    cfg_write(8'hFF, 2'd3, 8'd7);
    do_swap();
    send(8'd2, 1'b1, 24'd1, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    step();
    checks++;
    if (acc_out !== 24'd15) begin
      errors++; $display("FAIL addr_broadcast: got %0d, want 15", acc_out);
    end
  endtask

  task automatic test_hold_swap();
    cfg_write(8'h12, 2'd0, 8'd4);
    w_sel = 2'd0;
    send(8'd2, 1'b1, 24'd0, 1'b1);
    step();
    step();
    checks++;
    if (acc_out !== 24'd6 || acc_valid_out !== 1'b1 || mac_cnt !== 16'd3) begin
      errors++; $display("FAIL hold_pre: got acc=%0d av=%0b cnt=%0d, want 6/1/3", acc_out, acc_valid_out, mac_cnt);
    end
    hold = 1'b1; cfg_swap = 1'b1;
    send(8'd9, 1'b1, 24'd100, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      cfg_swap = 1'b0;
      checks++;
      if (x_out !== 8'd2 || x_valid_out !== 1'b1 || acc_out !== 24'd6 ||
          acc_valid_out !== 1'b1 || mac_cnt !== 16'd3) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: got x=%0d xv=%0b acc=%0d av=%0b cnt=%0d, want 2/1/6/1/3",
                 c, x_out, x_valid_out, acc_out, acc_valid_out, mac_cnt);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (x_out !== 8'd9 || acc_out !== 24'd6 || mac_cnt !== 16'd4) begin
      errors++; $display("FAIL hold_release: got x=%0d acc=%0d cnt=%0d, want 9/6/4", x_out, acc_out, mac_cnt);
    end
    step();
    checks++;
    if (acc_out !== 24'd127) begin
      errors++; $display("FAIL hold_old_bank: got %0d, want 127", acc_out);
    end
    step();
    checks++;
    if (acc_out !== 24'd136) begin
      errors++; $display("FAIL hold_new_bank: got %0d, want 136", acc_out);
    end
    send(8'd0, 1'b0, 24'd0, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_passthru_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
    send(8'd55, 1'b0, 24'd7, 1'b1);
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    checks++;
    if (x_out !== 8'd9 || x_valid_out !== 1'b0) begin
      errors++; $display("FAIL passthru_x_hold: got %0d/%0b, want 9/0", x_out, x_valid_out);
    end
    step();
    checks++;
    if (acc_out !== 24'd7 || acc_valid_out !== 1'b1 || mac_cnt !== 16'd0) begin
      errors++; $display("FAIL passthru_acc: got acc=%0d av=%0b cnt=%0d, want 7/1/0", acc_out, acc_valid_out, mac_cnt);
    end
    send(8'd3, 1'b1, 24'd11, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({x_out, x_valid_out, acc_out, acc_valid_out, ovf_flag, mac_cnt} !== 50'd0) begin
      errors++;
      $display("FAIL midstream_reset: got x=%0h xv=%0b acc=%0h av=%0b ovf=%0b cnt=%0d, want all 0",
               x_out, x_valid_out, acc_out, acc_valid_out, ovf_flag, mac_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    send(8'd0, 1'b0, 24'd0, 1'b0);
    checks++;
    if (acc_valid_out !== 1'b0 || x_out !== 8'd3) begin
      errors++; $display("FAIL post_reset_latency: got av=%0b x=%0d, want 0/3", acc_valid_out, x_out);
    end
    step();
    checks++;
    if (acc_out !== 24'd11 || acc_valid_out !== 1'b1) begin
      errors++; $display("FAIL post_reset_banks: got %0d/%0b, want 11/1", acc_out, acc_valid_out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    core_row = 4'd1; core_col = 4'd2;
    cfg_addr = 8'd0; cfg_widx = 2'd0; cfg_data = 8'd0; cfg_valid = 1'b0; cfg_swap = 1'b0;
    mode_signed = 1'b0; sat_en = 1'b0; w_sel = 2'd0; hold = 1'b0; clr = 1'b0;
    send(8'd0, 1'b0, 24'd0, 1'b0);
    repeat (2) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_signed();
    test_saturate();
    test_addr_decode();
    test_hold_swap();
    test_passthru_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_pe_db.md
TILE_PE_DB -- requirements
Module: tile_pe_db

Interface
REQ-001 SHALL have parameter DW, default 8: x and weight width.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width, ≥ 2*DW+1.
REQ-003 SHALL have parameter NW, default 4: weights per bank, power of two ≥ 2; WI_W = log2(NW).
REQ-004 SHALL have parameters ROW_W, default 4, and COL_W, default 4: tile ID field widths.
REQ-005 SHALL have port clk  input  1: clock, rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port core_row  input  ROW_W: tile row ID.
REQ-008 SHALL have port core_col  input  COL_W: tile column ID.
REQ-009 SHALL have port cfg_addr  input  ROW_W+COL_W: config target; all-ones means broadcast.
REQ-010 SHALL have port cfg_widx  input  WI_W: weight slot index.
REQ-011 SHALL have port cfg_data  input  DW: weight value.
REQ-012 SHALL have port cfg_valid  input  1: config write strobe.
REQ-013 SHALL have port cfg_swap  input  1: bank swap request pulse.
REQ-014 SHALL have port mode_signed  input  1: 1 = two's-complement operands, 0 = unsigned.
REQ-015 SHALL have port sat_en  input  1: 1 = saturate on overflow, 0 = wrap.
REQ-016 SHALL have port w_sel  input  WI_W: active-bank slot used by the MAC.
REQ-017 SHALL have port hold  input  1: pipeline stall.
REQ-018 SHALL have port clr  input  1: clears ovf_flag and mac_cnt.
REQ-019 SHALL have ports x_in  input  DW and x_valid_in  input  1: streamed operand.
REQ-020 SHALL have ports acc_in  input  ACC_W and acc_valid_in  input  1: partial sum.
REQ-021 SHALL have ports x_out  output  DW and x_valid_out  output  1: forwarded operand.
REQ-022 SHALL have ports acc_out  output  ACC_W and acc_valid_out  output  1: updated sum.
REQ-023 SHALL have ports ovf_flag  output  1 (sticky overflow) and mac_cnt  output  16 (MACs performed).

Function
REQ-024 SHALL hold two weight banks of NW entries each (one active, one shadow) and a bank_sel bit.
REQ-025 SHALL, when cfg_valid=1 and cfg_addr equals {core_row,core_col} or all-ones, write cfg_data into shadow[cfg_widx]; shadow is selected by the pre-swap bank_sel value. Config is accepted regardless of hold.
REQ-026 SHALL toggle bank_sel on cfg_swap=1 with hold=0. cfg_swap during hold=1 SHALL set swap_pend. The swap SHALL be applied on the first hold=0 cycle. Pending and new requests SHALL merge into one toggle.
REQ-027 SHALL implement a 2-state swap FSM: IDLE→PEND on cfg_swap&hold; PEND→IDLE on !hold (toggle applied).
REQ-028 SHALL, with hold=0, register x_out<=x_in and x_valid_out<=x_valid_in every cycle (latency 1).
REQ-029 SHALL run a 2-stage acc pipeline (latency 2).
  - Stage 1 registers acc_in, valid=acc_valid_in, and prod = x_valid_in ? active[w_sel]*x_in : 0.
  - Stage 2 produces acc_out and acc_valid_out.
REQ-030 SHALL form the product at 2*DW bits, signed or unsigned per mode_signed; extend it to ACC_W by sign or zero extension; compute the sum at ACC_W+1 bits.
REQ-031 SHALL define overflow.
  - Signed mode: the result sign is inconsistent with the operand signs.
  - Unsigned mode: carry out of bit ACC_W-1.
REQ-032 SHALL, on overflow with sat_en=1, clamp acc_out.
  - Signed mode: to 2^(ACC_W-1)-1, or to -2^(ACC_W-1) on underflow.
  - Unsigned mode: to 2^ACC_W-1.
  With sat_en=0, acc_out SHALL wrap.
REQ-033 SHALL set ovf_flag on any overflow of a valid stage-2 result, regardless of sat_en; it stays set until clr or reset.
REQ-034 SHALL increment mac_cnt on each valid stage-2 result whose stage-1 x_valid was 1; mac_cnt SHALL saturate at 16'hFFFF. clr SHALL take priority over an increment in the same cycle.
REQ-035 SHALL, when hold=1, freeze x_out, x_valid_out, both pipeline stages, acc_out, acc_valid_out, mac_cnt and ovf_flag; clr still applies during hold.
REQ-036 SHALL keep swaps from affecting a product that is already in stage 1.
REQ-037 SHALL keep acc_out and x_out at their last value when the corresponding valid is 0.

Reset
REQ-038 SHALL, on rst_n=0, asynchronously clear the following to 0: both banks, bank_sel, swap FSM (IDLE), pipeline registers, x_out, x_valid_out, acc_out, acc_valid_out, ovf_flag, mac_cnt.
REQ-039 SHALL discard in-flight data on reset mid-operation; the first valid output after reset SHALL appear at least 2 cycles after the first valid input.

Verification
REQ-040 Test: tile (1,2) in unsigned mode, shadow[0]=3, swap, x_in=5, acc_in=10, both valid → acc_out=25 and acc_valid_out=1 two cycles later; x_out=5 after one cycle; mac_cnt=1.
REQ-041 Test: signed mode, weight=-2 (8'hFE), x_in=100, acc_in=0 → acc_out=-200, sign-extended to 24 bits.
REQ-042 Test: signed mode, acc_in=2^23-1, product=+1.
  - With sat_en=1: acc_out=2^23-1 and ovf_flag=1.
  - With sat_en=0: acc_out=-2^23 and ovf_flag=1.
  - After a clr pulse: ovf_flag=0.
REQ-043 Test: write with cfg_addr to a different tile → no bank change. Write with cfg_addr all-ones → written. Write at cfg_widx=3 then swap, use w_sel=3 → that weight is used.
REQ-044 Test: cfg_swap with hold=1 for 3 cycles → bank unchanged during hold, swapped on the release cycle, outputs frozen throughout.
REQ-045 Test: x_valid_in=0 with acc_valid_in=1, acc_in=7 → acc_out=7 and mac_cnt unchanged. rst_n pulse mid-stream → all outputs 0 immediately.
